// File: rtl/ysyx_24100012_lsu_pkg.sv
// ysyx_24100012_lsu_pkg: func3 codes, FSM state encoding and defaults for the LSU.
// Rev 1.0
`default_nettype none

package ysyx_24100012_lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  localparam int TIMEOUT_DEFAULT = 255;

endpackage

`default_nettype wire

// File: rtl/ysyx_24100012_lsu_align.sv
// ysyx_24100012_lsu_align: legality check, store lane shifting and load extraction.
// Rev 1.0
`default_nettype none

module ysyx_24100012_lsu_align
  import ysyx_24100012_lsu_pkg::*;
(
  input  logic        wen,
  input  logic [2:0]  func3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [2:0]  ld_func3,
  input  logic [1:0]  ld_offset,
  input  logic [31:0] rdata,
  output logic        legal,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_sh,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    legal = 1'b0;
    case (func3)
      LB:      legal = 1'b1;
      LH:      legal = ~offset[0];
      LW:      legal = (offset == 2'b00);
      LBU:     legal = ~wen;
      LHU:     legal = ~wen & ~offset[0];
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    wstrb = 4'b1111;
    case (func3)
      SB:      wstrb = 4'b0001 << offset;
      SH:      wstrb = 4'b0011 << offset;
      default: wstrb = 4'b1111;
    endcase
    wdata_sh = wdata << {offset, 3'b000};
  end

  // Load path uses the captured op, not the live EXU inputs.
  always_comb begin
    shifted   = rdata >> {ld_offset, 3'b000};
    load_data = shifted;
    case (ld_func3)
      LB:      load_data = {{24{shifted[7]}}, shifted[7:0]};
      LBU:     load_data = {24'd0, shifted[7:0]};
      LH:      load_data = {{16{shifted[15]}}, shifted[15:0]};
      LHU:     load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ysyx_24100012_lsu.sv
// ysyx_24100012_lsu: multi-cycle single-outstanding load/store unit (EXU -> bus -> WBU).
// Rev 1.0. Optional WAIT watchdog enabled by defining YSYX_LSU_TIMEOUT_EN.
`default_nettype none

module ysyx_24100012_lsu
  import ysyx_24100012_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_wen,
  input  logic [2:0]            in_func3,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_wdata,
  input  logic [4:0]            in_rd,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_wen,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  output logic [3:0]            mem_req_wstrb,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_rdata,
  output logic [4:0]            out_rd,
  output logic                  out_is_load,
  output logic                  out_err
);

  lsu_state_t  state;
  logic        wen_q;
  logic [2:0]  func3_q;
  logic [1:0]  offset_q;

  logic        legal;
  logic [3:0]  strb;
  logic [31:0] wdata_sh;
  logic [31:0] load_data;

  ysyx_24100012_lsu_align u_align (
    .wen       (in_wen),
    .func3     (in_func3),
    .offset    (in_addr[1:0]),
    .wdata     (in_wdata),
    .ld_func3  (func3_q),
    .ld_offset (offset_q),
    .rdata     (mem_resp_rdata),
    .legal     (legal),
    .wstrb     (strb),
    .wdata_sh  (wdata_sh),
    .load_data (load_data)
  );

`ifdef YSYX_LSU_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      in_ready      <= 1'b1;
      wen_q         <= 1'b0;
      func3_q       <= 3'd0;
      offset_q      <= 2'd0;
      mem_req_valid <= 1'b0;
      mem_req_wen   <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_wstrb <= 4'd0;
      out_valid     <= 1'b0;
      out_rdata     <= '0;
      out_rd        <= 5'd0;
      out_is_load   <= 1'b0;
      out_err       <= 1'b0;
`ifdef YSYX_LSU_TIMEOUT_EN
      tmo_cnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            wen_q       <= in_wen;
            func3_q     <= in_func3;
            offset_q    <= in_addr[1:0];
            out_rd      <= in_rd;
            out_is_load <= ~in_wen;
            in_ready    <= 1'b0;
            if (legal) begin
              state         <= REQ;
              mem_req_valid <= 1'b1;
              mem_req_wen   <= in_wen;
              mem_req_addr  <= {in_addr[ADDR_WIDTH-1:2], 2'b00};
              mem_req_wdata <= in_wen ? wdata_sh : '0;
              mem_req_wstrb <= in_wen ? strb : 4'd0;
              out_err       <= 1'b0;
            end else begin
              // Illegal op completes without touching the bus.
              state     <= DONE;
              out_valid <= 1'b1;
              out_err   <= 1'b1;
              out_rdata <= '0;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT;
`ifdef YSYX_LSU_TIMEOUT_EN
            tmo_cnt       <= '0;
`endif
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            out_rdata <= wen_q ? '0 : load_data;
            out_err   <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
`ifdef YSYX_LSU_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            out_rdata <= '0;
            out_err   <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
